// File: rtl/m_ifetch_ir_if.sv
// rtl/m_ifetch_ir_if.sv - Wishbone classic read bus between the fetch sequencer and instruction memory
interface m_ifetch_ir_if;
    logic [31:0] ADR_O;
    logic        CYC_O;
    logic        STB_O;
    logic        WE_O;
    logic        ACK_I;
    logic        ERR_I;
    logic [31:0] DAT_I;

    modport master (
        output ADR_O, CYC_O, STB_O, WE_O,
        input  ACK_I, ERR_I, DAT_I
    );

    modport slave (
        input  ADR_O, CYC_O, STB_O, WE_O,
        output ACK_I, ERR_I, DAT_I
    );
endinterface

// File: rtl/m_ifetch_ir.sv
// rtl/m_ifetch_ir.sv - instruction fetch sequencer and instruction register
// Optional opcode legality flag: define M_IFETCH_ILLEGAL_CHECK_EN
module m_ifetch_ir #(
    parameter int          WAITW     = 4,
    parameter int          WAIT_MAX  = 15,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic               clk,
    input  logic               RST_I,
    input  logic               start_fetch,
    input  logic [31:0]        fadr,
    m_ifetch_ir_if.master      wb,
    output logic [31:0]        INSTR,
    output logic               sa11,
    output logic               busy,
    output logic               fetch_err,
    output logic               illegal
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_DECODE = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WAITW-1:0] wait_cnt;
    logic [31:0]      adr;
    logic             launch;
    logic             take_ack;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_ERR: if (start_fetch) state_next = S_REQ;
            S_REQ: begin
                if (wb.ERR_I)                           state_next = S_ERR;
                else if (wb.ACK_I)                      state_next = S_DECODE;
                else if (wait_cnt == WAITW'(WAIT_MAX))  state_next = S_ERR;
            end
            S_DECODE: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    assign launch   = ((state == S_IDLE) || (state == S_ERR)) && start_fetch;
    assign take_ack = (state == S_REQ) && (state_next == S_DECODE);

    always_ff @(posedge clk) begin
        if (RST_I) begin
            state     <= S_IDLE;
            adr       <= '0;
            INSTR     <= NOP_INSTR;
            fetch_err <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            state <= state_next;
            if (launch) begin
                adr       <= fadr;
                wait_cnt  <= '0;
                fetch_err <= 1'b0;
            end
            if (take_ack)
                INSTR <= wb.DAT_I;
            if (state == S_REQ && state_next == S_ERR)
                fetch_err <= 1'b1;
            if (state == S_REQ && state_next == S_REQ)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

`ifdef M_IFETCH_ILLEGAL_CHECK_EN
    function automatic logic opcode_legal(input logic [31:0] ins);
        logic ok;
        ok = 1'b0;
        if (ins[1:0] == 2'b11) begin
            case (ins[6:2])
                5'b00000, 5'b00100, 5'b11001, 5'b00101, 5'b01000, 5'b01100,
                5'b01101, 5'b11000, 5'b11011, 5'b11100, 5'b00010: ok = 1'b1;
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Flag is only meaningful alongside sa11, so it is dropped as DECODE is left.
    always_ff @(posedge clk) begin
        if (RST_I)
            illegal <= 1'b0;
        else if (take_ack)
            illegal <= ~opcode_legal(wb.DAT_I);
        else if (state == S_DECODE)
            illegal <= 1'b0;
    end
`else
    assign illegal = 1'b0;
`endif

    assign wb.ADR_O = adr;
    assign wb.CYC_O = (state == S_REQ);
    assign wb.STB_O = (state == S_REQ);
    assign wb.WE_O  = 1'b0;
    assign sa11     = (state == S_DECODE);
    assign busy     = (state == S_REQ) || (state == S_DECODE);

endmodule

// File: tb/tb_m_ifetch_ir.sv
// tb/tb_m_ifetch_ir.sv - directed self-checking bench for m_ifetch_ir
module tb_m_ifetch_ir;
    logic        clk = 1'b0;
    logic        RST_I;
    logic        start_fetch;
    logic [31:0] fadr;
    logic [31:0] INSTR;
    logic        sa11, busy, fetch_err, illegal;
    int          tests = 0;
    int          failed = 0;
    logic        exp_ill_7f;

    m_ifetch_ir_if bus ();

    m_ifetch_ir dut (
        .clk        (clk),
        .RST_I      (RST_I),
        .start_fetch(start_fetch),
        .fadr       (fadr),
        .wb         (bus.master),
        .INSTR      (INSTR),
        .sa11       (sa11),
        .busy       (busy),
        .fetch_err  (fetch_err),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef M_IFETCH_ILLEGAL_CHECK_EN
        exp_ill_7f = 1'b1;
`else
        exp_ill_7f = 1'b0;
`endif
        RST_I = 1'b1; start_fetch = 1'b0; fadr = '0;
        bus.ACK_I = 1'b0; bus.ERR_I = 1'b0; bus.DAT_I = '0;
        tick(); tick();
        check("rst_instr", INSTR, 32'h00000013);
        check("rst_cyc", {31'd0, bus.CYC_O}, 32'd0);
        check("rst_stb", {31'd0, bus.STB_O}, 32'd0);
        check("rst_sa11", {31'd0, sa11}, 32'd0);
        check("rst_ferr", {31'd0, fetch_err}, 32'd0);
        check("rst_adr", bus.ADR_O, 32'd0);
        check("rst_we", {31'd0, bus.WE_O}, 32'd0);
        RST_I = 1'b0;
        tick();

        // zero-wait fetch
        fadr = 32'h00000100; start_fetch = 1'b1;
        tick();
        start_fetch = 1'b0; bus.ACK_I = 1'b1; bus.DAT_I = 32'h00A00093;
        check("zw_cyc", {31'd0, bus.CYC_O}, 32'd1);
        check("zw_adr", bus.ADR_O, 32'h00000100);
        check("zw_busy", {31'd0, busy}, 32'd1);
        check("zw_sa11_early", {31'd0, sa11}, 32'd0);
        tick();
        bus.ACK_I = 1'b0;
        check("zw_sa11", {31'd0, sa11}, 32'd1);
        check("zw_instr", INSTR, 32'h00A00093);
        check("zw_cyc_off", {31'd0, bus.CYC_O}, 32'd0);
        check("zw_illegal", {31'd0, illegal}, 32'd0);
        tick();
        check("zw_sa11_once", {31'd0, sa11}, 32'd0);
        check("zw_busy_off", {31'd0, busy}, 32'd0);

        // three wait states then ACK
        fadr = 32'h00000200; start_fetch = 1'b1;
        tick();
        start_fetch = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("ws_cyc", {31'd0, bus.CYC_O}, 32'd1);
            tick();
        end
        check("ws_cyc4", {31'd0, bus.CYC_O}, 32'd1);
        check("ws_instr_hold", INSTR, 32'h00A00093);
        bus.ACK_I = 1'b1; bus.DAT_I = 32'hFE000EE3;
        tick();
        bus.ACK_I = 1'b0;
        check("ws_sa11", {31'd0, sa11}, 32'd1);
        check("ws_instr", INSTR, 32'hFE000EE3);
        check("ws_cyc_off", {31'd0, bus.CYC_O}, 32'd0);
        tick();
        check("ws_sa11_once", {31'd0, sa11}, 32'd0);

        // timeout: 16 ACK-less REQ cycles
        fadr = 32'h00000300; start_fetch = 1'b1;
        tick();
        start_fetch = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("to_cyc_last", {31'd0, bus.CYC_O}, 32'd1);
        check("to_ferr_early", {31'd0, fetch_err}, 32'd0);
        tick();
        check("to_ferr", {31'd0, fetch_err}, 32'd1);
        check("to_cyc_off", {31'd0, bus.CYC_O}, 32'd0);
        check("to_busy", {31'd0, busy}, 32'd0);
        check("to_instr", INSTR, 32'hFE000EE3);
        bus.ACK_I = 1'b1; bus.DAT_I = 32'h12345678;
        tick();
        bus.ACK_I = 1'b0;
        check("err_ack_ignored", INSTR, 32'hFE000EE3);
        check("err_ferr_held", {31'd0, fetch_err}, 32'd1);

        // recovery from ERR, opcode 1111111
        fadr = 32'h00000400; start_fetch = 1'b1;
        tick();
        start_fetch = 1'b0;
        check("rec_ferr_clr", {31'd0, fetch_err}, 32'd0);
        check("rec_adr", bus.ADR_O, 32'h00000400);
        bus.ACK_I = 1'b1; bus.DAT_I = 32'h0000007F;
        tick();
        bus.ACK_I = 1'b0;
        check("rec_instr", INSTR, 32'h0000007F);
        check("ill_7f", {31'd0, illegal}, {31'd0, exp_ill_7f});
        tick();
        check("ill_clr", {31'd0, illegal}, 32'd0);

        // LUI is legal; start during DECODE is dropped
        fadr = 32'h00000500; start_fetch = 1'b1;
        tick();
        start_fetch = 1'b0; bus.ACK_I = 1'b1; bus.DAT_I = 32'h00000037;
        tick();
        bus.ACK_I = 1'b0; start_fetch = 1'b1;
        check("lui_instr", INSTR, 32'h00000037);
        check("lui_illegal", {31'd0, illegal}, 32'd0);
        tick();
        start_fetch = 1'b0;
        check("dec_start_drop", {31'd0, busy}, 32'd0);
        check("dec_start_cyc", {31'd0, bus.CYC_O}, 32'd0);

        // ERR_I beats ACK_I
        fadr = 32'h00000600; start_fetch = 1'b1;
        tick();
        start_fetch = 1'b0; bus.ACK_I = 1'b1; bus.ERR_I = 1'b1; bus.DAT_I = 32'hDEADBEEF;
        tick();
        bus.ACK_I = 1'b0; bus.ERR_I = 1'b0;
        check("pri_ferr", {31'd0, fetch_err}, 32'd1);
        check("pri_instr", INSTR, 32'h00000037);
        check("pri_sa11", {31'd0, sa11}, 32'd0);
        check("pri_cyc", {31'd0, bus.CYC_O}, 32'd0);

        // reset in the middle of REQ
        fadr = 32'h00000700; start_fetch = 1'b1;
        tick();
        start_fetch = 1'b0;
        check("mr_cyc_on", {31'd0, bus.CYC_O}, 32'd1);
        RST_I = 1'b1; bus.ACK_I = 1'b1; bus.DAT_I = 32'hCAFEF00D;
        tick();
        RST_I = 1'b0; bus.ACK_I = 1'b0;
        check("mr_cyc", {31'd0, bus.CYC_O}, 32'd0);
        check("mr_instr", INSTR, 32'h00000013);
        check("mr_adr", bus.ADR_O, 32'd0);
        check("mr_ferr", {31'd0, fetch_err}, 32'd0);
        tick();
        check("mr_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/m_ifetch_ir.md
Name: m_ifetch_ir

Overview:
- Instruction fetch sequencer and instruction register; sits directly upstream of the immediate expander / zero-finder / Q stage.
- On request from the core sequencer, runs a Wishbone classic read at the address held in Q.
- Latches DAT_I into INSTR and asserts sa11 for exactly one decode cycle, so the downstream stage expands the immediate from the new instruction.
- Flags bus timeout, bus error and (optionally) illegal opcodes.

Parameters:
- WAITW, 4, width of the bus-wait counter.
- WAIT_MAX, 15, ACK-less cycles in REQ before timeout; must be ≤ 2^WAITW-1.
- NOP_INSTR, 32'h00000013, reset/flush value of INSTR (addi x0,x0,0).

Ports:
- clk  in  1  system clock.
- RST_I  in  1  synchronous reset, active high.
- start_fetch  in  1  request a fetch; sampled only in IDLE or ERR.
- fadr  in  32  fetch address; driven from Q (ADR_O of the expander stage); must be stable while CYC_O=1.
- ADR_O  out  32  Wishbone address; equals fadr registered at request start.
- CYC_O  out  1  Wishbone cycle.
- STB_O  out  1  Wishbone strobe.
- WE_O  out  1  constant 0.
- ACK_I  in  1  Wishbone acknowledge.
- ERR_I  in  1  Wishbone error.
- DAT_I  in  32  Wishbone read data.
- INSTR  out  32  instruction register.
- sa11  out  1  decode cycle; immediate expand enable for the downstream stage.
- busy  out  1  high in REQ or DECODE.
- fetch_err  out  1  sticky bus error/timeout flag.
- illegal  out  1  decoded-opcode illegal flag, valid while sa11=1.

Behaviour:
- Reset values (any edge with RST_I=1, overrides all else):
  - State IDLE; CYC_O=STB_O=0.
  - ADR_O=0, INSTR=NOP_INSTR.
  - sa11=0, fetch_err=0, illegal=0, wait counter=0.
  - Reset during REQ drops CYC_O/STB_O on that same edge; no INSTR update.
- IDLE:
  - start_fetch=1 → REQ next cycle.
  - Same edge: ADR_O<=fadr, CYC_O=STB_O=1, counter<=0.
- REQ:
  - ERR_I=1 (priority over ACK_I) → ERR. CYC_O/STB_O low next cycle, fetch_err<=1, INSTR unchanged.
  - Else ACK_I=1 → DECODE. INSTR<=DAT_I, CYC_O/STB_O low next cycle.
  - Else counter==WAIT_MAX → ERR, as for ERR_I.
  - Else counter increments; no wrap possible.
  - Minimum latency: start_fetch edge to sa11=1 is 2 cycles with zero-wait ACK.
- DECODE:
  - sa11=1 for exactly one cycle; INSTR stable.
  - Next state IDLE unconditionally; start_fetch is ignored in DECODE.
- ERR:
  - fetch_err held; CYC_O=0.
  - start_fetch=1 → clears fetch_err and starts REQ exactly as from IDLE.
- Other rules:
  - ACK_I/ERR_I outside REQ are ignored.
  - start_fetch during REQ/DECODE is dropped, not queued.
  - busy = (state==REQ) | (state==DECODE).
  - INSTR changes only on an ACK in REQ or on reset.

Optional Feature:
- Macro: M_IFETCH_ILLEGAL_CHECK_EN.
- Enabled: on the ACK edge, illegal<=1 unless DAT_I[1:0]==2'b11 and DAT_I[6:2] is one of 00000, 00100, 11001, 00101, 01000, 01100, 01101, 11000, 11011, 11100, 00010. The registered flag is valid in DECODE and cleared on leaving DECODE.
- Disabled: illegal tied 0 and no decode logic is synthesised.

Test Plan:
- Reset: hold RST_I 2 cycles → INSTR=32'h00000013, CYC_O=0, sa11=0, fetch_err=0.
- Zero-wait fetch: fadr=32'h00000100, pulse start_fetch, ACK_I in the first REQ cycle with DAT_I=32'h00A00093 → ADR_O=32'h100, INSTR=32'h00A00093, sa11=1 for one cycle 2 cycles after start, busy low after.
- Wait states: ACK_I after 3 wait cycles, DAT_I=32'hFE000EE3 → CYC_O high 4 cycles, then INSTR updates and sa11 pulses once.
- Timeout and recovery: no ACK → after WAIT_MAX+1=16 REQ cycles, fetch_err=1 and CYC_O=0. Then start_fetch plus ACK → fetch_err clears and INSTR loads.
- Priority and reset: ACK_I=ERR_I=1 together → ERR, INSTR unchanged. RST_I mid-REQ → CYC_O=0 next cycle, INSTR=NOP_INSTR.
- Illegal check (macro on): DAT_I=32'h0000007F → illegal=1 during sa11. DAT_I=32'h00000037 (LUI) → illegal=0. With macro off, illegal stays 0 in both cases.
